// File: rtl/multi_entry_write_buffer_if.sv
// Bus bundle between the L2-side requester / pmem model (master) and the eviction write buffer (slave).
interface multi_entry_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              flush;
    logic              flush_done;
    logic              full;
    logic              empty;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, flush, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, flush_done, full, empty,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, flush, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, flush_done, full, empty,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/multi_entry_write_buffer.sv
// DEPTH-entry eviction write buffer: absorbs dirty lines, coalesces rewrites,
// serves read hits locally and drains to pmem in FIFO order when the upstream is idle.
module multi_entry_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multi_entry_write_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ} state_t;

    state_t            state;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [LINE_W-1:0] entry_data [DEPTH];

    logic              match;
    logic [PTR_W-1:0]  match_idx;
    logic              full;
    logic              wr_hit;
    logic              wr_enq;
    logic              rd_hit;

    assign full = (count == CNT_W'(DEPTH));

    // Coalescing keeps addresses unique, so at most one entry can match.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entry_addr[i] == bus.mem_address) begin
                match     = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        wr_hit        = 1'b0;
        wr_enq        = 1'b0;
        rd_hit        = 1'b0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = entry_data[match_idx];
        case (state)
            S_IDLE: begin
                if (bus.mem_write) begin
                    wr_hit = match;
                    wr_enq = !match && !full;
                end else if (bus.mem_read) begin
                    rd_hit = match;
                end
            end
            S_DRAIN: rd_hit = bus.mem_read && match;
            S_READ: begin
                bus.mem_rdata = bus.pmem_rdata;
                bus.mem_resp  = bus.pmem_resp;
            end
            default: ;
        endcase
        if (wr_hit || wr_enq || rd_hit) begin
            bus.mem_resp = 1'b1;
        end
    end

    assign bus.pmem_write   = (state == S_DRAIN);
    assign bus.pmem_read    = (state == S_READ);
    assign bus.pmem_address = (state == S_DRAIN) ? entry_addr[head] : bus.mem_address;
    assign bus.pmem_wdata   = entry_data[head];
    assign bus.full         = full;
    assign bus.empty        = (count == '0);
    assign bus.flush_done   = bus.flush && (count == '0) && (state == S_IDLE);

    // Line storage carries no reset; only valid bits qualify it.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            entry_data[match_idx] <= bus.mem_wdata;
        end else if (wr_enq) begin
            entry_addr[tail] <= bus.mem_address;
            entry_data[tail] <= bus.mem_wdata;
        end
    end

    // An idle drain never starts on an empty buffer, so flush only gates flush_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mem_write) begin
                        if (wr_enq) begin
                            valid[tail] <= 1'b1;
                            tail        <= tail + 1'b1;
                            count       <= count + 1'b1;
                        end else if (!match) begin
                            state <= S_DRAIN;
                        end
                    end else if (bus.mem_read) begin
                        if (!match) begin
                            state <= S_READ;
                        end
                    end else if (count != '0) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.pmem_resp) begin
                        valid[head] <= 1'b0;
                        head        <= head + 1'b1;
                        count       <= count - 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (bus.pmem_resp) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_entry_write_buffer.sv
// Directed bench for multi_entry_write_buffer: a queue-level model checked every cycle,
// plus hand-computed expectations for latency, ordering and returned data.
module tb_multi_entry_write_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } txn_t;

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;
    int   pmem_lat;
    int   resp_wait;

    ent_t mq [$];
    bit   m_drain;
    bit   m_read;
    bit   m_valid;
    txn_t plog [$];

    int                hit;
    logic              e_resp;
    logic              e_prd;
    logic              e_pwr;
    logic [LINE_W-1:0] e_rdata;
    logic [ADDR_W-1:0] e_paddr;
    logic [LINE_W-1:0] e_wdata;

    multi_entry_write_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    multi_entry_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic [LINE_W-1:0] lineOf(input int k);
        return {(LINE_W/32){32'hA000_0000 + 32'(k)}};
    endfunction

    function automatic logic [LINE_W-1:0] mkRdata(input logic [ADDR_W-1:0] a);
        return {(LINE_W/ADDR_W){~a}};
    endfunction

    function automatic int mFind(input logic [ADDR_W-1:0] a);
        foreach (mq[i]) begin
            if (mq[i].addr == a) return i;
        end
        return -1;
    endfunction

    // pmem model: answers a request after pmem_lat cycles; pmem_lat==0 holds it off indefinitely.
    initial begin
        resp_wait       = 0;
        bus.pmem_resp   = 1'b0;
        bus.pmem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
            if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
                resp_wait++;
                if (pmem_lat != 0 && resp_wait >= pmem_lat) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = mkRdata(bus.pmem_address);
                    resp_wait      = 0;
                end
            end else begin
                resp_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.pmem_resp && (bus.pmem_read || bus.pmem_write)) begin
            plog.push_back('{bus.pmem_write, bus.pmem_address, bus.pmem_wdata});
        end
    end

    // Queue-level model: the buffer is an ordered list of lines plus one outstanding pmem job.
    always @(negedge clk) begin
        if (m_valid) begin
            hit     = mFind(bus.mem_address);
            e_resp  = 1'b0;
            e_prd   = 1'b0;
            e_pwr   = 1'b0;
            e_rdata = '0;
            e_paddr = '0;
            e_wdata = '0;
            if (m_read) begin
                e_prd   = 1'b1;
                e_paddr = bus.mem_address;
                e_resp  = bus.pmem_resp;
                e_rdata = bus.pmem_rdata;
            end else if (m_drain) begin
                e_pwr   = 1'b1;
                e_paddr = mq[0].addr;
                e_wdata = mq[0].data;
                if (bus.mem_read && hit >= 0) begin
                    e_resp  = 1'b1;
                    e_rdata = mq[hit].data;
                end
            end else if (bus.mem_write) begin
                e_resp = (hit >= 0) || (mq.size() < DEPTH);
            end else if (bus.mem_read && hit >= 0) begin
                e_resp  = 1'b1;
                e_rdata = mq[hit].data;
            end

            checkOutput("mem_resp", LINE_W'(bus.mem_resp), LINE_W'(e_resp));
            checkOutput("pmem_read", LINE_W'(bus.pmem_read), LINE_W'(e_prd));
            checkOutput("pmem_write", LINE_W'(bus.pmem_write), LINE_W'(e_pwr));
            checkOutput("full", LINE_W'(bus.full), LINE_W'(mq.size() == DEPTH));
            checkOutput("empty", LINE_W'(bus.empty), LINE_W'(mq.size() == 0));
            checkOutput("flush_done", LINE_W'(bus.flush_done),
                        LINE_W'(bus.flush && mq.size() == 0 && !m_drain && !m_read));
            if (e_resp && bus.mem_read)
                checkOutput("mem_rdata", bus.mem_rdata, e_rdata);
            if (e_prd || e_pwr)
                checkOutput("pmem_address", LINE_W'(bus.pmem_address), LINE_W'(e_paddr));
            if (e_pwr)
                checkOutput("pmem_wdata", bus.pmem_wdata, e_wdata);
        end

        if (!rst_n) begin
            mq.delete();
            m_drain = 1'b0;
            m_read  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_read) begin
                if (bus.pmem_resp) m_read = 1'b0;
            end else if (m_drain) begin
                if (bus.pmem_resp) begin
                    void'(mq.pop_front());
                    m_drain = 1'b0;
                end
            end else if (bus.mem_write) begin
                if (hit >= 0) mq[hit].data = bus.mem_wdata;
                else if (mq.size() < DEPTH) mq.push_back('{bus.mem_address, bus.mem_wdata});
                else m_drain = 1'b1;
            end else if (bus.mem_read) begin
                if (hit < 0) m_read = 1'b1;
            end else if (mq.size() > 0) begin
                m_drain = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [LINE_W-1:0] data, output int waited,
                                 output logic [LINE_W-1:0] rdata);
        bit done;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.mem_address = addr;
        bus.mem_wdata   = data;
        waited = 0;
        rdata  = '0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                rdata = bus.mem_rdata;
                done  = 1'b1;
            end else begin
                waited++;
                if (waited > 60) begin
                    timeoutFail("request response");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // what: 0 = buffer empty and no pmem job, 1 = drain in progress, 2 = flush_done
    task automatic waitUntil(input int what, input int bound, input string name);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done) begin
            @(negedge clk);
            case (what)
                0:       done = bus.empty && !bus.pmem_read && !bus.pmem_write;
                1:       done = bus.pmem_write;
                default: done = bus.flush_done;
            endcase
            n++;
            if (!done && n >= bound) begin
                timeoutFail(name);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int                w;
    int                base;
    logic [LINE_W-1:0] rd;

    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        m_valid         = 1'b0;
        m_drain         = 1'b0;
        m_read          = 1'b0;
        pmem_lat        = 2;
        rst_n           = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mem_resp", LINE_W'(bus.mem_resp), '0);
        checkOutput("reset pmem_write", LINE_W'(bus.pmem_write), '0);
        checkOutput("reset pmem_read", LINE_W'(bus.pmem_read), '0);
        checkOutput("reset full", LINE_W'(bus.full), '0);
        checkOutput("reset empty", LINE_W'(bus.empty), LINE_W'(1));
        rst_n = 1'b1;

        $display("[TB] burst of four writes");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h1000 + 32'(k * 'h40), lineOf(k), w, rd);
            checkOutput("burst write latency", LINE_W'(w), '0);
        end
        checkOutput("burst full", LINE_W'(bus.full), LINE_W'(1));
        checkOutput("burst no drain", LINE_W'(bus.pmem_write), '0);
        checkOutput("burst no pmem log", LINE_W'(plog.size()), '0);

        $display("[TB] write miss while full");
        applyStimulus(1'b0, 1'b1, 32'h1100, lineOf(4), w, rd);
        checkOutput("full-miss latency", LINE_W'(w), LINE_W'(3));
        checkOutput("full-miss one drain", LINE_W'(plog.size()), LINE_W'(1));
        checkOutput("full-miss drained addr", LINE_W'(plog[0].addr), LINE_W'(32'h1000));
        checkOutput("full-miss drained data", plog[0].data, lineOf(0));
        checkOutput("full-miss full again", LINE_W'(bus.full), LINE_W'(1));

        $display("[TB] reset during a drain");
        pmem_lat = 0;
        waitUntil(1, 10, "drain start");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid-drain reset pmem_write", LINE_W'(bus.pmem_write), '0);
        checkOutput("mid-drain reset empty", LINE_W'(bus.empty), LINE_W'(1));
        checkOutput("mid-drain reset full", LINE_W'(bus.full), '0);
        rst_n    = 1'b1;
        pmem_lat = 2;
        applyStimulus(1'b0, 1'b1, 32'h2000, lineOf(16), w, rd);
        checkOutput("post-reset write latency", LINE_W'(w), '0);
        waitUntil(0, 40, "post-reset drain");
        checkOutput("post-reset drain count", LINE_W'(plog.size()), LINE_W'(2));
        checkOutput("post-reset drained addr", LINE_W'(plog[1].addr), LINE_W'(32'h2000));

        $display("[TB] coalescing rewrite and read hit");
        base = plog.size();
        applyStimulus(1'b0, 1'b1, 32'h1040, LINE_W'('h11), w, rd);
        applyStimulus(1'b0, 1'b1, 32'h1040, LINE_W'('h22), w, rd);
        checkOutput("rewrite latency", LINE_W'(w), '0);
        applyStimulus(1'b1, 1'b0, 32'h1040, '0, w, rd);
        checkOutput("read hit latency", LINE_W'(w), '0);
        checkOutput("read hit data", rd, LINE_W'('h22));
        checkOutput("coalesced not empty", LINE_W'(bus.empty), '0);
        waitUntil(0, 40, "coalesced drain");
        checkOutput("coalesced single drain", LINE_W'(plog.size() - base), LINE_W'(1));
        checkOutput("coalesced drain data", plog[base].data, LINE_W'('h22));

        $display("[TB] read miss with two buffered lines");
        base = plog.size();
        applyStimulus(1'b0, 1'b1, 32'h3000, lineOf(30), w, rd);
        applyStimulus(1'b0, 1'b1, 32'h3040, lineOf(31), w, rd);
        applyStimulus(1'b1, 1'b0, 32'h4000, '0, w, rd);
        checkOutput("read miss latency", LINE_W'(w), LINE_W'(2));
        checkOutput("read miss data", rd, mkRdata(32'h4000));
        checkOutput("read miss kept lines", LINE_W'(bus.empty), '0);
        waitUntil(0, 40, "read-miss drain");
        checkOutput("read-miss log size", LINE_W'(plog.size() - base), LINE_W'(3));
        checkOutput("read before drain", LINE_W'(plog[base].wr), '0);
        checkOutput("first drain after read", LINE_W'(plog[base + 1].addr), LINE_W'(32'h3000));
        checkOutput("second drain after read", LINE_W'(plog[base + 2].addr), LINE_W'(32'h3040));

        $display("[TB] flush of three lines");
        base     = plog.size();
        pmem_lat = 3;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h5000 + 32'(k * 'h40), lineOf(50 + k), w, rd);
        end
        bus.flush = 1'b1;
        waitUntil(2, 60, "flush_done");
        checkOutput("flush empty", LINE_W'(bus.empty), LINE_W'(1));
        checkOutput("flush drain count", LINE_W'(plog.size() - base), LINE_W'(3));
        for (int k = 0; k < 3; k++) begin
            checkOutput("flush order", LINE_W'(plog[base + k].addr), LINE_W'(32'h5000 + 32'(k * 'h40)));
        end
        bus.flush = 1'b0;
        #1;
        checkOutput("flush_done released", LINE_W'(bus.flush_done), '0);

        $display("[TB] head hits during a drain");
        base     = plog.size();
        pmem_lat = 0;
        applyStimulus(1'b0, 1'b1, 32'h6000, LINE_W'('hE0), w, rd);
        waitUntil(1, 10, "head drain start");
        applyStimulus(1'b1, 1'b0, 32'h6000, '0, w, rd);
        checkOutput("drain read hit latency", LINE_W'(w), '0);
        checkOutput("drain read hit data", rd, LINE_W'('hE0));
        pmem_lat = 2;
        applyStimulus(1'b0, 1'b1, 32'h6000, LINE_W'('hE1), w, rd);
        checkOutput("head write stalled", LINE_W'(w >= 1), LINE_W'(1));
        waitUntil(0, 40, "head re-drain");
        checkOutput("head drain count", LINE_W'(plog.size() - base), LINE_W'(2));
        checkOutput("old head data", plog[base].data, LINE_W'('hE0));
        checkOutput("requeued head data", plog[base + 1].data, LINE_W'('hE1));

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
